// File: rtl/uart_tx_core.sv
// uart_tx_core: queued UART transmitter.
// A small FIFO feeds a frame FSM (START, DATA LSB first, optional parity,
// STOP) whose every bit lasts baud_div+1 clocks, with baud_div sampled once
// per frame. tx_out comes straight from a flop.
module uart_tx_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 wr_en, pop;

    state_t               state_q, state_nxt;
    logic [DIV_W-1:0]     tick_q, tick_nxt;
    logic [DIV_W-1:0]     div_q, div_nxt;
    logic [BIT_W-1:0]     bit_q, bit_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 par_q, par_nxt;
    logic                 tx_q, tx_nxt;
    logic                 last_tick, start_frame;

    assign s_ready    = (level != FULL_LVL);
    assign wr_en      = s_valid && s_ready;
    assign fifo_level = level;
    assign tx_out     = tx_q;
    assign tx_busy    = (state_q != IDLE);

    // Queue storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_data;
    end

    // Queue pointers and occupancy; simultaneous write and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Frame FSM state, bit timing and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_nxt;
            tick_q  <= tick_nxt;
            div_q   <= div_nxt;
            bit_q   <= bit_nxt;
            shift_q <= shift_nxt;
            par_q   <= par_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // Next-state logic; the value of tx_nxt is what the line shows next clock.
    always_comb begin
        state_nxt   = state_q;
        tick_nxt    = tick_q;
        div_nxt     = div_q;
        bit_nxt     = bit_q;
        shift_nxt   = shift_q;
        par_nxt     = par_q;
        tx_nxt      = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        last_tick   = (tick_q == div_q);

        case (state_q)
            IDLE: begin
                tx_nxt = 1'b1;
                if (level != '0) start_frame = 1'b1;
            end
            START: begin
                if (last_tick) begin
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end else begin
                    tick_nxt = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    tick_nxt = '0;
                    if (bit_q == LAST_DATA) begin
                        bit_nxt = '0;
                        if (PARITY != 0) begin
                            state_nxt = PAR;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_q + 1'b1;
                        shift_nxt = shift_q >> 1;
                        tx_nxt    = shift_q[1];
                    end
                end else begin
                    tick_nxt = tick_q + 1'b1;
                end
            end
            PAR: begin
                if (last_tick) begin
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    tick_nxt = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    tick_nxt = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                        if (level != '0) start_frame = 1'b1;
                    end else begin
                        bit_nxt = bit_q + 1'b1;
                    end
                end else begin
                    tick_nxt = tick_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (start_frame) begin
            pop       = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
            tick_nxt  = '0;
            bit_nxt   = '0;
            div_nxt   = baud_div;
            shift_nxt = mem[rd_ptr];
            par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 2);
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench for uart_tx_core with three parameter sets
// (defaults/even parity, odd parity, no parity with two stop bits).
module tb_uart_tx_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sv  [3];
    logic [7:0] sd  [3];
    logic [15:0] bd [3];
    logic       rdy [3];
    logic       txo [3];
    logic       bsy [3];
    logic [2:0] lvl [3];

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    uart_tx_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_def (
        .clk(clk), .rst_n(rst_n), .baud_div(bd[0]), .s_data(sd[0]), .s_valid(sv[0]),
        .s_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]), .fifo_level(lvl[0]));

    uart_tx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .baud_div(bd[1]), .s_data(sd[1]), .s_valid(sv[1]),
        .s_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]), .fifo_level(lvl[1]));

    uart_tx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u_nopar (
        .clk(clk), .rst_n(rst_n), .baud_div(bd[2]), .s_data(sd[2]), .s_valid(sv[2]),
        .s_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(bsy[2]), .fifo_level(lvl[2]));

    function automatic int par_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; the byte joins the scoreboard only if it is accepted.
    task automatic write_byte(input int s, input logic [7:0] d, input string name);
        sd[s] = d;
        sv[s] = 1'b1;
        tests++;
        if (rdy[s] !== 1'b1) begin
            fails++;
            $display("FAIL %s s_ready: got %b, required 1", name, rdy[s]);
        end else begin
            exp_q.push_back(d);
        end
        tick();
        sv[s] = 1'b0;
    endtask

    // Waits for a start bit, pops the expected byte and checks every clock of the frame.
    task automatic check_frame(input int s, input int div, input bit immediate, input string name);
        logic [7:0]  d;
        logic [15:0] bits;
        int          n, waited, par;
        bit          ok, busy_ok;
        waited = 0;
        tick();
        while (txo[s] !== 1'b0 && waited < 2000) begin
            waited++;
            tick();
        end
        if (txo[s] !== 1'b0) begin
            tests++; fails++;
            $display("FAIL %s start: tx_out=%b, required 0 within 2000 clocks", name, txo[s]);
            return;
        end
        if (immediate) begin
            tests++;
            if (waited != 0) begin
                fails++;
                $display("FAIL %s gap: start after %0d idle clocks, required 0", name, waited);
            end
        end
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard: frame seen with no byte queued, required none", name);
            return;
        end
        d    = exp_q.pop_front();
        par  = par_of(s);
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (par != 0) begin
            bits[n] = (^d) ^ (par == 2);
            n++;
        end
        for (int i = 0; i < stop_of(s); i++) begin
            bits[n] = 1'b1;
            n++;
        end
        busy_ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            ok = 1'b1;
            for (int c = 0; c <= div; c++) begin
                if (b != 0 || c != 0) tick();
                if (txo[s] !== bits[b]) ok = 1'b0;
                if (bsy[s] !== 1'b1) busy_ok = 1'b0;
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s bit%0d of 0x%02h: tx_out deviated, required %b for %0d clocks",
                         name, b, d, bits[b], div + 1);
            end
        end
        tests++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL %s tx_busy: dropped during frame, required 1 throughout", name);
        end
    endtask

    task automatic check_idle(input int s, input string name);
        tick();
        tests++;
        if (txo[s] !== 1'b1 || bsy[s] !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: tx_out=%b tx_busy=%b, required 1/0", name, txo[s], bsy[s]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0; sd[s] = '0; bd[s] = 16'd3;
        end
        #23;
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (txo[s] !== 1'b1 || bsy[s] !== 1'b0 || rdy[s] !== 1'b1 || lvl[s] !== 3'd0) begin
                fails++;
                $display("FAIL reset[%0d]: tx=%b busy=%b rdy=%b lvl=%0d, required 1/0/1/0",
                         s, txo[s], bsy[s], rdy[s], lvl[s]);
            end
        end
        #9 rst_n = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) check_idle(s, "post_reset");
    endtask

    task automatic test_basic();
        bd[0] = 16'd3;
        write_byte(0, 8'hA5, "a5");
        tests++;
        if (txo[0] !== 1'b1 || lvl[0] !== 3'd1) begin
            fails++;
            $display("FAIL a5 write_edge: tx=%b lvl=%0d, required 1/1", txo[0], lvl[0]);
        end
        check_frame(0, 3, 1'b1, "a5");
        check_idle(0, "a5");
    endtask

    task automatic test_parity_modes();
        bd[1] = 16'd1;
        write_byte(1, 8'h01, "odd01");
        check_frame(1, 1, 1'b1, "odd01");
        check_idle(1, "odd01");
        write_byte(1, 8'h03, "odd03");
        check_frame(1, 1, 1'b1, "odd03");
        check_idle(1, "odd03");
        bd[2] = 16'd0;
        write_byte(2, 8'h5A, "nopar");
        check_frame(2, 0, 1'b1, "nopar");
        check_idle(2, "nopar");
    endtask

    task automatic test_back_to_back();
        bd[0] = 16'd2;
        fork
            begin
                write_byte(0, 8'h00, "b2b");
                write_byte(0, 8'hFF, "b2b");
                write_byte(0, 8'h55, "b2b");
            end
            begin
                check_frame(0, 2, 1'b0, "b2b0");
                check_frame(0, 2, 1'b1, "b2b1");
                check_frame(0, 2, 1'b1, "b2b2");
            end
        join
        check_idle(0, "b2b");
    endtask

    task automatic test_fifo_full();
        logic [7:0] data [6];
        int waited;
        data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bd[0] = 16'd1;
        fork
            begin
                sv[0] = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    sd[0] = data[i];
                    if (i == 5) begin
                        tests++;
                        if (lvl[0] !== 3'd4 || rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                            fails++;
                            $display("FAIL full: lvl=%0d rdy=%b busy=%b, required 4/0/1",
                                     lvl[0], rdy[0], bsy[0]);
                        end
                    end
                    waited = 0;
                    while (rdy[0] !== 1'b1 && waited < 500) begin
                        tick();
                        waited++;
                    end
                    if (rdy[0] !== 1'b1) begin
                        tests++; fails++;
                        $display("FAIL full accept%0d: s_ready stuck at %b, required 1", i, rdy[0]);
                    end else begin
                        exp_q.push_back(data[i]);
                        tick();
                    end
                end
                sv[0] = 1'b0;
                tests++;
                if (lvl[0] !== 3'd4) begin
                    fails++;
                    $display("FAIL full refill: lvl=%0d, required 4", lvl[0]);
                end
            end
            begin
                check_frame(0, 1, 1'b0, "full0");
                for (int i = 1; i < 6; i++) check_frame(0, 1, 1'b1, "fullN");
            end
        join
        check_idle(0, "full");
    endtask

    task automatic test_baud_change();
        bd[0] = 16'd3;
        fork
            begin
                write_byte(0, 8'h3C, "baud");
                write_byte(0, 8'hC3, "baud");
                repeat (10) tick();
                bd[0] = 16'd7;
            end
            begin
                check_frame(0, 3, 1'b0, "baud_old");
                check_frame(0, 7, 1'b1, "baud_new");
            end
        join
        check_idle(0, "baud");
        bd[0] = 16'd3;
    endtask

    task automatic test_reset_mid();
        bit quiet;
        bd[0] = 16'd3;
        write_byte(0, 8'h11, "rst");
        write_byte(0, 8'h22, "rst");
        write_byte(0, 8'h33, "rst");
        repeat (8) tick();
        tests++;
        if (txo[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst pre: tx=%b busy=%b, required 0/1 (data bit1 of 0x11)", txo[0], bsy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (txo[0] !== 1'b1 || bsy[0] !== 1'b0 || lvl[0] !== 3'd0 || rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst async: tx=%b busy=%b lvl=%0d rdy=%b, required 1/0/0/1",
                     txo[0], bsy[0], lvl[0], rdy[0]);
        end
        exp_q.delete();
        #3 rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (txo[0] !== 1'b1 || bsy[0] !== 1'b0 || lvl[0] !== 3'd0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL rst quiet: activity after reset, required tx=1 busy=0 lvl=0");
        end
        write_byte(0, 8'h96, "post_rst");
        check_frame(0, 3, 1'b1, "post_rst");
        check_idle(0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_modes();
        test_back_to_back();
        test_fifo_full();
        test_baud_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 The block SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL provide parameter PARITY, default 1, meaning the parity mode: 0 none, 1 even, 2 odd.
REQ-003 The block SHALL provide parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 The block SHALL provide parameter FIFO_DEPTH, default 4, meaning the transmit queue depth (power of two, at least 2).
REQ-005 The block SHALL provide parameter DIV_W, default 16, meaning the width of the baud divisor.
REQ-006 The block SHALL provide port clk, input, width 1: the single system clock; all logic is rising-edge on clk, with no derived clocks.
REQ-007 The block SHALL provide port rst_n, input, width 1: asynchronous active-low reset.
REQ-008 The block SHALL provide port baud_div, input, width DIV_W: clocks per bit minus 1.
REQ-009 The block SHALL provide port s_data, input, width DATA_BITS: the byte to queue.
REQ-010 The block SHALL provide port s_valid, input, width 1: s_data is valid.
REQ-011 The block SHALL provide port s_ready, output, width 1: the queue can accept s_data.
REQ-012 The block SHALL provide port tx_out, output, width 1: serial line, idle high.
REQ-013 The block SHALL provide port tx_busy, output, width 1: a frame is in progress.
REQ-014 The block SHALL provide port fifo_level, output, width $clog2(FIFO_DEPTH)+1: number of queued, not-yet-started entries.

Function
REQ-015 A write SHALL occur on every rising edge where s_valid and s_ready are both high; s_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-016 s_valid while s_ready is low SHALL be ignored, with no data loss and no error flag.
REQ-017 The FSM SHALL have exactly these states: IDLE, START, DATA, PAR, STOP.
REQ-018 In IDLE with fifo_level nonzero, the next edge SHALL pop the head entry, latch baud_div into a frame-local divisor, enter START and drive tx_out low.
REQ-019 Latency: a write at edge k into an empty queue with the FSM in IDLE SHALL produce tx_out low from edge k+1.
REQ-020 Every bit SHALL last exactly latched_div+1 clocks, counted by an internal tick counter; baud_div=0 SHALL give 1 clock per bit.
REQ-021 Changes to baud_div during a frame SHALL have no effect until the next frame.
REQ-022 DATA SHALL send DATA_BITS bits LSB first.
REQ-023 The PAR bit SHALL be sent only when PARITY != 0.
REQ-024 In even mode the PAR bit SHALL be the XOR of the data bits; in odd mode it SHALL be the inverse of that XOR.
REQ-025 STOP SHALL hold tx_out high for STOP_BITS bit periods.
REQ-026 At the end of the final stop bit with the queue non-empty, the next START SHALL begin on the immediately following edge, with no idle gap; with the queue empty, the FSM SHALL return to IDLE.
REQ-027 Frame length SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * (latched_div + 1) clocks.
REQ-028 A write and a pop on the same edge SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 tx_busy SHALL be high in every state except IDLE, and tx_out SHALL be registered (glitch-free).

Reset
REQ-031 While rst_n is low, the block SHALL hold tx_out=1, tx_busy=0, s_ready=1, fifo_level=0, the FSM in IDLE, and all counters and pointers at 0.
REQ-032 Reset mid-frame SHALL force tx_out high immediately (asynchronously) and discard both the partial frame and all queued entries.
REQ-033 After rst_n deasserts, the first edge SHALL accept a write, and the block SHALL start no frame until data is written.

Verification
REQ-034 The bench SHALL cover: defaults, baud_div=3, write 0xA5 -> tx_out sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each 4 clocks, 44 clocks total, tx_busy high throughout.
REQ-035 The bench SHALL cover: PARITY=2, write 0x01 -> parity bit 0; PARITY=0, STOP_BITS=2, baud_div=0 -> 11-clock frame with no parity bit.
REQ-036 The bench SHALL cover: FIFO_DEPTH=4, writes 0x00, 0xFF, 0x55 on consecutive edges -> three contiguous frames, no idle clock between them, s_ready never low.
REQ-037 The bench SHALL cover: FIFO_DEPTH=4, s_valid held high with 6 bytes -> 5 accepted (1 in flight, 4 queued), s_ready low, fifo_level=4; the 6th is accepted at the first pop edge.
REQ-038 The bench SHALL cover: baud_div changed 3->7 mid-frame -> current frame keeps 4 clocks/bit, next frame uses 8 clocks/bit.
REQ-039 The bench SHALL cover: rst_n pulsed low during the DATA bits of the first of 3 queued frames -> tx_out=1 immediately, fifo_level=0, and no further frames are sent.
